// File: rtl/seg7_scan_sched.sv
// Time-multiplexed 8-digit seven-segment driver with two arbitrated write ports,
// shadow/active double buffering committed at frame boundaries, and leading-zero blanking.
module seg7_scan_sched #(
    parameter int DIGIT_CYC = 50000,
    parameter int GAP_CYC   = 1000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wa_valid,
    input  logic [2:0] wa_addr,
    input  logic [3:0] wa_data,
    output logic       wa_ready,
    input  logic       wb_valid,
    input  logic [2:0] wb_addr,
    input  logic [3:0] wb_data,
    output logic       wb_ready,
    input  logic       commit,
    input  logic       lz_en,
    output logic [7:0] seg_data,
    output logic [7:0] seg_sel,
    output logic       frame_done,
    output logic       dbg_digit,
    output logic [2:0] dbg_idx
);

    localparam int MAXC = (DIGIT_CYC > GAP_CYC) ? DIGIT_CYC : GAP_CYC;
    localparam int CW   = (MAXC < 2) ? 1 : $clog2(MAXC + 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic {
        S_GAP   = 1'b0,
        S_DIGIT = 1'b1
    } state_t;

    state_t        state, state_nxt;
    logic [2:0]    idx, idx_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [3:0]    shadow [8];
    logic [3:0]    active [8];
    logic [3:0]    active_nxt [8];
    logic          pending;
    logic          rr_b;
    logic          grant_a, grant_b;
    logic          boundary, do_copy;
    logic [7:0]    lz_blank;
    logic [3:0]    code_nxt;
    logic [7:0]    seg_data_nxt, seg_sel_nxt;

    function automatic logic [7:0] decode(input logic [3:0] code);
        case (code)
            4'd0:    decode = 8'hFC;
            4'd1:    decode = 8'h60;
            4'd2:    decode = 8'hDA;
            4'd3:    decode = 8'hF2;
            4'd4:    decode = 8'h66;
            4'd5:    decode = 8'hB6;
            4'd6:    decode = 8'hBE;
            4'd7:    decode = 8'hE0;
            4'd8:    decode = 8'hFE;
            4'd9:    decode = 8'hF6;
            4'd10:   decode = 8'h02;
            default: decode = 8'h00;
        endcase
    endfunction

    // A write transfers on the rising edge of any cycle where valid && ready; ready is a
    // same-cycle grant, at most one port is ready, and rr_b names the port favoured on a tie.
    always_comb begin
        grant_a = wa_valid && (!wb_valid || !rr_b);
        grant_b = wb_valid && (!wa_valid || rr_b);
    end

    assign wa_ready  = grant_a && rst;
    assign wb_ready  = grant_b && rst;
    assign dbg_digit = (state == S_DIGIT);
    assign dbg_idx   = idx;

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        cnt_nxt   = cnt + CNT_ONE;
        boundary  = 1'b0;
        if (state == S_GAP) begin
            if (cnt == CW'(GAP_CYC - 1)) begin
                state_nxt = S_DIGIT;
                idx_nxt   = idx + 3'd1;
                cnt_nxt   = '0;
                boundary  = (idx == 3'd7);
            end
        end else if (cnt == CW'(DIGIT_CYC - 1)) begin
            state_nxt = S_GAP;
            cnt_nxt   = '0;
        end
    end

    // The copy reads shadow before this edge's write, so a boundary-cycle write waits a frame.
    always_comb begin
        do_copy = boundary && (pending || commit);
        for (int i = 0; i < 8; i++) begin
            active_nxt[i] = do_copy ? shadow[i] : active[i];
        end
        lz_blank    = '0;
        lz_blank[7] = (active_nxt[7] == 4'd0);
        for (int k = 6; k >= 1; k--) begin
            lz_blank[k] = lz_blank[k+1] && (active_nxt[k] == 4'd0);
        end
        code_nxt     = active_nxt[idx_nxt];
        seg_data_nxt = 8'h00;
        seg_sel_nxt  = 8'hFF;
        if (state_nxt == S_DIGIT) begin
            seg_sel_nxt = ~(8'h01 << idx_nxt);
            if (!(lz_en && lz_blank[idx_nxt])) begin
                seg_data_nxt = decode(code_nxt);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_GAP;
            idx        <= 3'd7;
            cnt        <= '0;
            pending    <= 1'b0;
            rr_b       <= 1'b0;
            frame_done <= 1'b0;
            seg_data   <= 8'h00;
            seg_sel    <= 8'hFF;
            for (int i = 0; i < 8; i++) begin
                shadow[i] <= 4'hF;
                active[i] <= 4'hF;
            end
        end else begin
            state      <= state_nxt;
            idx        <= idx_nxt;
            cnt        <= cnt_nxt;
            pending    <= do_copy ? 1'b0 : (pending || commit);
            frame_done <= do_copy;
            seg_data   <= seg_data_nxt;
            seg_sel    <= seg_sel_nxt;
            if (wa_valid && wb_valid) begin
                rr_b <= grant_a;
            end
            if (grant_a) begin
                shadow[wa_addr] <= wa_data;
            end else if (grant_b) begin
                shadow[wb_addr] <= wb_data;
            end
            for (int i = 0; i < 8; i++) begin
                active[i] <= active_nxt[i];
            end
        end
    end

endmodule
